// File: rtl/core_pkg.sv
// core_pkg: shared bus types, error-cause struct and bit indices.
package core_pkg;
  localparam int BUS_ERR_TRAP = 0;
  localparam int BUS_ERR_UNMAPPED = 1;
  localparam int BUS_ERR_MULTI = 2;
  localparam int BUS_ERR_TIMEOUT = 3;
  typedef struct packed {
    logic timeout;
    logic multi;
    logic unmapped;
    logic trap;
  } bus_err_cause_t;
  typedef enum logic {IDLE, ACTIVE} bus_state_t;
endpackage

// File: rtl/bus_err_trap.sv
// bus_err_trap: sticky bus-error flag with cause accumulation and first-address capture.
module bus_err_trap
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  bus_err_cause_t ev,
  input  logic [31:0]    a,
  input  logic [31:0]    cyc_a,
  output logic           error,
  output bus_err_cause_t cause,
  output logic [31:0]    err_a
);
  logic           error_q, error_d;
  bus_err_cause_t cause_q, cause_d;
  logic [31:0]    err_a_q, err_a_d;
  logic           any_ev;
  // clear is applied first so an event in the same cycle reloads the registers
  always_comb begin
    any_ev = |ev;
    error_d = (clr ? 1'b0 : error_q) | any_ev;
    cause_d = bus_err_cause_t'((clr ? 4'b0 : cause_q) | ev);
    err_a_d = clr ? 32'h0 : err_a_q;
    if (any_ev && (clr || !error_q)) err_a_d = ev.trap ? a : cyc_a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
      cause_q <= '0;
      err_a_q <= '0;
    end else begin
      error_q <= error_d;
      cause_q <= cause_d;
      err_a_q <= err_a_d;
    end
  end
  assign error = error_q;
  assign cause = cause_q;
  assign err_a = err_a_q;
endmodule

// File: rtl/cpu_bus_mux.sv
// cpu_bus_mux: V810 read-data/READYn return mux with cycle FSM, forced termination and error trap.
module cpu_bus_mux
  import core_pkg::*;
#(
  parameter int                  NSLV      = 5,
  parameter int                  DW        = 32,
  parameter int                  TO_CYCLES = 1024,
  parameter int                  NTRAP     = 2,
  parameter logic [NTRAP*32-1:0] TRAP_A    = {32'hFFFFFF90, 32'hFFFFFFD0}
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic               CE,
  input  logic               BCYSTn,
  input  logic               MRQn,
  input  logic               RW,
  input  logic [31:0]        A,
  input  logic [NSLV-1:0]    SLV_CEn,
  input  logic [NSLV*DW-1:0] SLV_DO,
  input  logic [NSLV-1:0]    SLV_READYn,
  output logic [DW-1:0]      CPU_DI,
  output logic               CPU_READYn,
  output logic               BUSY,
  input  logic               ERR_CLR,
  output logic               ERROR,
  output logic [3:0]         ERR_CAUSE,
  output logic [31:0]        ERR_A
);
  localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
  localparam int WW = $clog2(TO_CYCLES);
  bus_state_t     state_q, state_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [31:0]    cyc_a_q, cyc_a_d;
  logic [NSLV-1:0] cs;
  logic [SW-1:0]  sel;
  logic           active, hit, multi, to_hit, rdy, trap_hit;
  bus_err_cause_t ev, cause;
  logic           unused_rw;
  assign unused_rw = RW;
  always_comb begin
    cs = ~SLV_CEn;
    sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) if (cs[i]) sel = SW'(i);
    trap_hit = 1'b0;
    for (int i = 0; i < NTRAP; i++) if (A == TRAP_A[i*32 +: 32]) trap_hit = 1'b1;
  end
  assign active = state_q == ACTIVE;
  assign hit = |cs;
  assign multi = |(cs & (cs - NSLV'(1)));
  assign to_hit = wcnt_q == WW'(TO_CYCLES - 1);
  assign rdy = active & (~hit | ~SLV_READYn[sel] | to_hit);
  assign CPU_READYn = ~rdy;
  assign CPU_DI = (active & hit) ? SLV_DO[sel*DW +: DW] : '0;
  assign BUSY = active;
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    cyc_a_d = cyc_a_q;
    if (CE) begin
      if (!active || rdy) begin
        state_d = BCYSTn ? IDLE : ACTIVE;
        wcnt_d = '0;
        cyc_a_d = BCYSTn ? cyc_a_q : A;
      end else begin
        wcnt_d = wcnt_q + WW'(1);
      end
    end
  end
  // timeout is only a cause when it actually forces the end
  always_comb begin
    ev.trap = CE & ~BCYSTn & ~MRQn & trap_hit;
    ev.unmapped = CE & active & ~hit;
    ev.multi = CE & active & multi;
    ev.timeout = CE & active & hit & SLV_READYn[sel] & to_hit;
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      cyc_a_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      cyc_a_q <= cyc_a_d;
    end
  end
  bus_err_trap u_trap (
    .clk  (CLK),
    .rst  (RES),
    .clr  (ERR_CLR),
    .ev   (ev),
    .a    (A),
    .cyc_a(cyc_a_q),
    .error(ERROR),
    .cause(cause),
    .err_a(ERR_A)
  );
  assign ERR_CAUSE = cause;
endmodule

// File: tb/tb_cpu_bus_mux.sv
// tb_cpu_bus_mux: directed scoreboard bench; monitor checks data and ACTIVE-cycle count at each ready.
module tb_cpu_bus_mux;
  localparam int NSLV = 5;
  localparam int DW = 32;
  logic               CLK = 0, RES = 1, CE = 1, BCYSTn = 1, MRQn = 1, RW = 1, ERR_CLR = 0;
  logic [31:0]        A = '0;
  logic [NSLV-1:0]    SLV_CEn = '1, SLV_READYn = '1;
  logic [NSLV*DW-1:0] SLV_DO = '0;
  logic [DW-1:0]      CPU_DI;
  logic               CPU_READYn, BUSY, ERROR;
  logic [3:0]         ERR_CAUSE;
  logic [31:0]        ERR_A;
  typedef struct {logic [31:0] di; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cnt = 0;

  cpu_bus_mux #(.NSLV(NSLV), .DW(DW), .TO_CYCLES(8)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .BCYSTn(BCYSTn), .MRQn(MRQn), .RW(RW), .A(A),
    .SLV_CEn(SLV_CEn), .SLV_DO(SLV_DO), .SLV_READYn(SLV_READYn),
    .CPU_DI(CPU_DI), .CPU_READYn(CPU_READYn), .BUSY(BUSY),
    .ERR_CLR(ERR_CLR), .ERROR(ERROR), .ERR_CAUSE(ERR_CAUSE), .ERR_A(ERR_A)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] di, input int c);
    exp_t e;
    e.di = di;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic chk_err(input string n, input logic e, input logic [3:0] c, input logic [31:0] a);
    chk({n, "_error"}, 32'(ERROR), 32'(e));
    chk({n, "_cause"}, 32'(ERR_CAUSE), 32'(c));
    chk({n, "_err_a"}, ERR_A, a);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RES) cnt = 0;
    else if (CE && BUSY) begin
      cnt++;
      if (!CPU_READYn) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got ready at A-cycle %0d expected none", cnt);
        end else begin
          e = q.pop_front();
          chk("ready_data", CPU_DI, e.di);
          chk("ready_cycle", 32'(cnt), 32'(e.cyc));
        end
        cnt = 0;
      end
    end
  end

  initial begin
    cyc(); cyc();
    RES = 0;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_readyn", 32'(CPU_READYn), 1);
    chk("rst_di", CPU_DI, 0);
    chk_err("rst", 0, 4'b0000, 0);
    // zero-wait read from slave 1
    A = 32'h0000_1000; BCYSTn = 0; push(32'h1234_5678, 1);
    cyc();
    BCYSTn = 1; SLV_CEn = 5'b11101; SLV_READYn = 5'b11101; SLV_DO[1*DW +: DW] = 32'h1234_5678;
    cyc();
    chk("zw_idle", 32'(BUSY), 0);
    chk("zw_noerr", 32'(ERROR), 0);
    SLV_CEn = '1; SLV_READYn = '1;
    // slave 2, three waits with a CE-low hold, then back-to-back
    A = 32'h0000_2000; BCYSTn = 0; push(32'hCAFE_0002, 4);
    cyc();
    BCYSTn = 1; SLV_CEn = 5'b11011; SLV_DO[2*DW +: DW] = 32'hCAFE_0002;
    cyc();
    CE = 0; cyc(); CE = 1;
    cyc(); cyc();
    SLV_READYn = 5'b11011; BCYSTn = 0; A = 32'h0000_3000; push(32'hCAFE_0003, 1);
    cyc();
    chk("b2b_busy", 32'(BUSY), 1);
    BCYSTn = 1; SLV_DO[2*DW +: DW] = 32'hCAFE_0003;
    cyc();
    chk("b2b_idle", 32'(BUSY), 0);
    chk("b2b_noerr", 32'(ERROR), 0);
    SLV_CEn = '1; SLV_READYn = '1;
    // unmapped
    A = 32'h8000_0000; BCYSTn = 0; push(0, 1);
    cyc();
    BCYSTn = 1;
    cyc();
    chk_err("unmapped", 1, 4'b0010, 32'h8000_0000);
    ERR_CLR = 1; cyc(); ERR_CLR = 0;
    chk_err("clr1", 0, 4'b0000, 0);
    // multi-select with timeout after 8 ACTIVE cycles
    A = 32'h0000_4000; BCYSTn = 0; push(32'hAAAA_0000, 8);
    cyc();
    BCYSTn = 1; SLV_CEn = 5'b10110;
    SLV_DO[0*DW +: DW] = 32'hAAAA_0000; SLV_DO[3*DW +: DW] = 32'hBBBB_0003;
    repeat (8) cyc();
    chk("to_idle", 32'(BUSY), 0);
    chk_err("timeout", 1, 4'b1100, 32'h0000_4000);
    SLV_CEn = '1;
    ERR_CLR = 1; cyc(); ERR_CLR = 0;
    // trap at a mapped cycle, then clear together with a new unmapped end
    MRQn = 0; A = 32'hFFFF_FF90; BCYSTn = 0; push(32'h4444_4444, 1);
    cyc();
    BCYSTn = 1; SLV_CEn = 5'b01111; SLV_READYn = 5'b01111; SLV_DO[4*DW +: DW] = 32'h4444_4444;
    cyc();
    chk_err("trap", 1, 4'b0001, 32'hFFFF_FF90);
    SLV_CEn = '1; SLV_READYn = '1;
    A = 32'h9000_0000; BCYSTn = 0; push(0, 1);
    cyc();
    BCYSTn = 1; ERR_CLR = 1;
    cyc();
    ERR_CLR = 0;
    chk_err("clr_ev", 1, 4'b0010, 32'h9000_0000);
    // reset while waiting, with CE low
    A = 32'h0000_5000; BCYSTn = 0;
    cyc();
    BCYSTn = 1; SLV_CEn = 5'b11101;
    cyc();
    chk("pre_rst_busy", 32'(BUSY), 1);
    CE = 0; RES = 1;
    cyc();
    RES = 0; CE = 1;
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_readyn", 32'(CPU_READYn), 1);
    chk("mid_rst_di", CPU_DI, 0);
    chk_err("mid_rst", 0, 4'b0000, 0);
    SLV_CEn = '1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_bus_mux.md
# cpu_bus_mux

Parametrised CPU-side bus return path for the PC-FX machine: selects read data and READYn from N memory/I/O slaves according to their chip-selects, tracks each V810 bus cycle with a small state machine, and terminates hung or unmapped cycles itself. Sits between `fx_ga` chip-select outputs, the memory and I/O data sources, and the `v810` `D_I`/`READYn` inputs. It also provides a sticky, clearable bus-error trap with cause and address capture.

## Interface
Parameters:
- NSLV, 5: number of slave channels. Index 0 has the highest priority.
- DW, 32: data width.
- TO_CYCLES, 1024: CE-cycle wait limit before forced termination. Must be ≥2.
- NTRAP, 2: number of trap addresses.
- TRAP_A, {32'hFFFFFF90, 32'hFFFFFFD0}: packed NTRAP×32 trap addresses.

Ports:
- CLK  in  1  system clock
- RES  in  1  reset, synchronous, active-high
- CE  in  1  CPU clock enable
- BCYSTn  in  1  CPU bus-cycle start
- MRQn  in  1  CPU memory request
- RW  in  1  CPU read (1) or write (0)
- A  in  32  CPU address
- SLV_CEn  in  NSLV  slave chip-selects, active-low
- SLV_DO  in  NSLV×DW  slave read data, packed, with slave i at [i*DW +: DW]
- SLV_READYn  in  NSLV  slave ready, active-low
- CPU_DI  out  DW  read data to CPU
- CPU_READYn  out  1  ready to CPU
- BUSY  out  1  a bus cycle is in progress (state ACTIVE)
- ERR_CLR  in  1  clears the error trap
- ERROR  out  1  sticky error flag
- ERR_CAUSE  out  4  accumulated causes: bit0 TRAP, bit1 UNMAPPED, bit2 MULTI, bit3 TIMEOUT
- ERR_A  out  32  address of the first error since clear

## Operation
- **State machine:** two states, IDLE and ACTIVE. All state updates are gated by CE; ERR_CLR and RES act regardless of CE.
- **Starting a cycle:** in IDLE, CE & ~BCYSTn captures A into cyc_a and moves to ACTIVE. Wait counter wcnt is cleared to 0.
- **Slave selection (ACTIVE):** sel is the lowest index i with SLV_CEn[i]=0.
  - hit = at least one CEn low.
  - multi = two or more CEn low. The cycle proceeds using sel, and MULTI is logged.
- **Read data:** CPU_DI = SLV_DO[sel] when ACTIVE & hit, else 0. This is combinational.
- **CPU_READYn:** low (combinational) when ACTIVE and any of the following holds:
  - hit & SLV_READYn[sel] = 0 (normal end);
  - ~hit (UNMAPPED, forced end, CPU_DI = 0);
  - wcnt = TO_CYCLES-1 (TIMEOUT, forced end, CPU_DI as selected).

  It is 1 at all other times.
- **End of cycle:** a CE cycle with CPU_READYn low in ACTIVE ends the cycle.
  - Next state is ACTIVE if ~BCYSTn in that same cycle (back-to-back; recapture A, wcnt = 0), else IDLE.
- **Waiting:** in ACTIVE, a CE cycle without an end increments wcnt. wcnt is $clog2(TO_CYCLES) bits and never wraps, because TIMEOUT ends the cycle first.
- **TRAP:** CE & ~BCYSTn & ~MRQn & A equals any TRAP_A entry. Logged in the BCYSTn cycle; the cycle itself proceeds normally.
- **Error logging:** on any cause event in a CE cycle:
  - ERR_CAUSE |= cause bits;
  - if ERROR was 0, ERR_A takes the offending address (A for TRAP, cyc_a otherwise) and ERROR becomes 1.
  - Multiple causes in one cycle are all ORed in. If both TRAP and another cause occur, ERR_A = A.
- **ERR_CLR:** clears ERROR, ERR_CAUSE and ERR_A. A cause event in the same cycle wins: the registers are cleared, then the new event is loaded.
- **Writes:** writes use the identical path; CPU_DI is ignored by the CPU.

## Timing
- **Reset values:** RES high forces state IDLE, wcnt 0, ERROR 0, ERR_CAUSE 0, ERR_A 0. Hence CPU_READYn 1, CPU_DI 0, BUSY 0 from the following cycle on.
- **Reset mid-operation:** RES during ACTIVE abandons the cycle with no error logged.
- **Minimum bus cycle:** 2 CE cycles (BCYSTn cycle, then the ready cycle with a zero-wait slave). No added latency on data or ready; both are combinational from slave inputs.
- **Forced termination:**
  - UNMAPPED ends on the first ACTIVE CE cycle.
  - TIMEOUT ends on the TO_CYCLES-th ACTIVE CE cycle.
- **CE low:** holds all state. Outputs remain combinationally valid.
- **ERROR timing:** ERROR rises on the CLK edge following the CE cycle of the event.

## Structure
- core_pkg gains `bus_err_cause_t` (4-bit packed struct: timeout, multi, unmapped, trap) and the BUS_ERR_* bit-index localparams.
- One sub-module, `bus_err_trap`: sticky cause/address capture with ERR_CLR priority rules. The FSM and mux stay in cpu_bus_mux.

## Test plan
- **Zero-wait read:** BCYSTn low at A=0x0000_1000; next CE cycle SLV_CEn[1]=0, SLV_READYn[1]=0, SLV_DO[1]=0x1234_5678 -> CPU_READYn=0 and CPU_DI=0x1234_5678 in that cycle; state returns to IDLE; ERROR stays 0.
- **Wait states, back-to-back:** slave 2 ready after 3 waits, BCYSTn low again in the ready cycle -> CPU_READYn low only on the 4th ACTIVE cycle; new cycle starts immediately with wcnt=0.
- **Unmapped:** BCYSTn at A=0x8000_0000 with all SLV_CEn=1 -> CPU_READYn=0 and CPU_DI=0 on the next CE cycle; ERROR=1, ERR_CAUSE=0b0010, ERR_A=0x8000_0000.
- **Multi-select and timeout:** TO_CYCLES=8, SLV_CEn[0] and SLV_CEn[3] low, READYn held high -> CPU_DI follows slave 0; CPU_READYn low exactly on ACTIVE cycle 8; ERR_CAUSE=0b1100.
- **Trap and clear:** MRQn low, BCYSTn low at A=0xFFFF_FF90 -> ERROR=1, ERR_CAUSE=0b0001, ERR_A=0xFFFF_FF90. Then ERR_CLR together with a new unmapped end -> ERR_CAUSE=0b0010 with the new address.
- **Reset mid-cycle:** RES asserted in ACTIVE with CE=0 -> next cycle BUSY=0, CPU_READYn=1, and ERROR/ERR_CAUSE/ERR_A are all 0.
